adc_bitslip_align: RTL and testbench

//  Word-alignment controller directly downstream of the 8-lane ADC deserializer.
//  - Watches the 64-bit deserialized word (8 lanes x 8 bits) while the ADC sends its training pattern.
//  - Pulses the shared bitslip line until every lane byte matches the pattern, then declares lock.
//  - Once locked, forwards registered sample data to the acquisition path.

---
 rtl/adc_align_pkg.sv | 23 ++
 rtl/adc_lane_cmp.sv | 20 ++
 rtl/adc_bitslip_align.sv | 143 ++++++++++++++
 tb/tb_adc_bitslip_align.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_align_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_align_pkg
//  Description : Shared types and sizes for the ADC word-alignment controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package adc_align_pkg;

    localparam int NUM_LANES = 8;
    localparam int LANE_W    = 8;
    localparam int MAX_SLIPS = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        CHECK  = 3'd2,
        SLIP   = 3'd3,
        LOCKED = 3'd4,
        FAIL   = 3'd5
    } align_state_t;

endpackage
`default_nettype wire

// File: rtl/adc_lane_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : adc_lane_cmp
//  Description : Flags a single deserialized lane byte that differs from the
//                training pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_lane_cmp
    import adc_align_pkg::*;
#(
    parameter logic [LANE_W-1:0] TRAIN_PATTERN = 8'hF0
) (
    input  logic [LANE_W-1:0] i_lane_data,
    output logic              o_mismatch
);

    assign o_mismatch = (i_lane_data != TRAIN_PATTERN);

endmodule
`default_nettype wire

// File: rtl/adc_bitslip_align.sv
`default_nettype none
// ============================================================================
//  Module      : adc_bitslip_align
//  Description : Issues bitslip pulses until all ADC lanes show the training
//                pattern, then declares lock and forwards registered samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_bitslip_align
    import adc_align_pkg::*;
#(
    parameter logic [LANE_W-1:0] TRAIN_PATTERN = 8'hF0,
    parameter int                SETTLE_CYCLES = 4,
    parameter int                MATCH_CYCLES  = 16
) (
    input  logic                        divclk,
    input  logic                        rst_n,
    input  logic [NUM_LANES*LANE_W-1:0] data_deser,
    input  logic                        align_start,
    output logic                        bitslip,
    output logic                        locked,
    output logic                        fail,
    output logic [2:0]                  slip_count,
    output logic [NUM_LANES-1:0]        lane_err,
    output logic [NUM_LANES*LANE_W-1:0] data_out,
    output logic                        data_valid
);

    localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] c_match_last  = 8'(MATCH_CYCLES - 1);
    localparam logic [2:0] c_max_slips   = 3'(MAX_SLIPS);

    align_state_t                r_state;
    align_state_t                w_next_state;
    logic [3:0]                  r_settle_cnt;
    logic [7:0]                  r_match_cnt;
    logic [2:0]                  r_slip_count;
    logic [NUM_LANES-1:0]        r_lane_err;
    logic [NUM_LANES*LANE_W-1:0] r_data_out;
    logic                        r_data_valid;
    logic [NUM_LANES-1:0]        w_mismatch;
    logic                        w_all_match;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        adc_lane_cmp #(
            .TRAIN_PATTERN (TRAIN_PATTERN)
        ) u_lane_cmp (
            .i_lane_data (data_deser[k*LANE_W +: LANE_W]),
            .o_mismatch  (w_mismatch[k])
        );
    end

    assign w_all_match = ~|w_mismatch;

    always_ff @(posedge divclk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A restart pre-empts whatever the current state would do next.
    always_comb begin
        w_next_state = r_state;
        if (align_start) begin
            w_next_state = SETTLE;
        end else begin
            case (r_state)
                SETTLE: begin
                    if (r_settle_cnt == c_settle_last) begin
                        w_next_state = CHECK;
                    end
                end
                CHECK: begin
                    if (w_all_match) begin
                        if (r_match_cnt == c_match_last) begin
                            w_next_state = LOCKED;
                        end
                    end else if (r_slip_count == c_max_slips) begin
                        w_next_state = FAIL;
                    end else begin
                        w_next_state = SLIP;
                    end
                end
                SLIP:    w_next_state = SETTLE;
                default: w_next_state = r_state;
            endcase
        end
    end

    always_comb begin
        bitslip = (r_state == SLIP);
        locked  = (r_state == LOCKED);
        fail    = (r_state == FAIL);
    end

    always_ff @(posedge divclk) begin
        if (!rst_n) begin
            r_settle_cnt <= '0;
            r_match_cnt  <= '0;
            r_slip_count <= '0;
            r_lane_err   <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_out   <= data_deser;
            r_data_valid <= (w_next_state == LOCKED);
            if (align_start) begin
                r_settle_cnt <= '0;
                r_match_cnt  <= '0;
                r_slip_count <= '0;
                r_lane_err   <= '0;
            end else begin
                case (r_state)
                    SETTLE: begin
                        r_match_cnt  <= '0;
                        r_settle_cnt <= (r_settle_cnt == c_settle_last) ? 4'd0 : r_settle_cnt + 4'd1;
                    end
                    CHECK: begin
                        r_lane_err <= w_mismatch;
                        if (w_all_match) begin
                            r_match_cnt <= r_match_cnt + 8'd1;
                        end
                    end
                    SLIP: begin
                        r_slip_count <= r_slip_count + 3'd1;
                        r_settle_cnt <= '0;
                    end
                    default: begin
                        r_settle_cnt <= r_settle_cnt;
                    end
                endcase
            end
        end
    end

    assign slip_count = r_slip_count;
    assign lane_err   = r_lane_err;
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;

endmodule
`default_nettype wire

// File: tb/tb_adc_bitslip_align.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_bitslip_align
//  Description : Directed bench with a bit-rotating deserializer model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_bitslip_align;

    logic        divclk = 1'b0;
    logic        rst_n;
    logic [63:0] data_deser;
    logic        align_start;
    logic        bitslip;
    logic        locked;
    logic        fail;
    logic [2:0]  slip_count;
    logic [7:0]  lane_err;
    logic [63:0] data_out;
    logic        data_valid;

    int checks   = 0;
    int failures = 0;

    always #5 divclk = ~divclk;

    adc_bitslip_align dut (
        .divclk      (divclk),
        .rst_n       (rst_n),
        .data_deser  (data_deser),
        .align_start (align_start),
        .bitslip     (bitslip),
        .locked      (locked),
        .fail        (fail),
        .slip_count  (slip_count),
        .lane_err    (lane_err),
        .data_out    (data_out),
        .data_valid  (data_valid)
    );

    // Deserializer model: each accepted slip lowers the rotation by one bit,
    // visible two cycles after the pulse.
    logic [2:0]  off_init;
    logic [7:0]  stuck_mask;
    logic        corrupt;
    logic        model_en;
    logic        model_clr;
    logic        use_free;
    logic [63:0] free_word;
    logic        slip_d1;
    logic [2:0]  slip_acc;
    logic [63:0] exp_q;
    logic [2:0]  eff_off;

    function automatic logic [7:0] rotl8(input logic [7:0] b, input logic [2:0] n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    always @(posedge divclk) begin
        if (model_clr) begin
            slip_d1  <= 1'b0;
            slip_acc <= 3'd0;
        end else begin
            slip_d1 <= bitslip & model_en;
            if (slip_d1) slip_acc <= slip_acc + 3'd1;
        end
        exp_q <= data_deser;
    end

    assign eff_off = off_init - slip_acc;

    always_comb begin
        data_deser = '0;
        for (int k = 0; k < 8; k++) begin
            data_deser[8*k +: 8] = stuck_mask[k] ? 8'h00 : rotl8(8'hF0, eff_off);
        end
        if (corrupt)  data_deser[7:0] = data_deser[7:0] ^ 8'h01;
        if (use_free) data_deser = free_word;
    end

    task automatic tick();
        @(posedge divclk);
        @(negedge divclk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input logic [2:0] off, input logic [7:0] stuck);
        off_init   = off;
        stuck_mask = stuck;
        model_clr  = 1'b1;
        tick();
        model_clr  = 1'b0;
    endtask

    // Starts a training run and follows it until lock or fail; cycle 1 is the
    // first cycle after align_start is sampled.
    task automatic train(input string tag, input int exp_pulses, input int exp_cycle,
                         input bit exp_fail, input int budget);
        int pulses  = 0;
        int low_run = 0;
        int min_low = 1000;
        int cyc;
        bit done    = 1'b0;
        align_start = 1'b1;
        tick();
        align_start = 1'b0;
        cyc = 1;
        chk({tag, "_c1_locked"}, 64'(locked), 64'd0);
        chk({tag, "_c1_slipcnt"}, 64'(slip_count), 64'd0);
        while (!done && cyc < budget) begin
            chk({tag, "_data_out"}, data_out, exp_q);
            if (bitslip) begin
                if (pulses > 0 && low_run < min_low) min_low = low_run;
                pulses++;
                low_run = 0;
            end else begin
                low_run++;
            end
            if (locked || fail) begin
                done = 1'b1;
            end else begin
                tick();
                cyc++;
            end
        end
        chk({tag, "_finished"}, 64'(done), 64'd1);
        chk({tag, "_pulses"}, 64'(pulses), 64'(exp_pulses));
        chk({tag, "_cycle"}, 64'(cyc), 64'(exp_cycle));
        chk({tag, "_gap_ge4"}, 64'(min_low >= 4), 64'd1);
        chk({tag, "_locked"}, 64'(locked), 64'(!exp_fail));
        chk({tag, "_fail"}, 64'(fail), 64'(exp_fail));
        chk({tag, "_valid"}, 64'(data_valid), 64'(!exp_fail));
        chk({tag, "_slipcnt"}, 64'(slip_count), 64'(exp_pulses));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bitslip"}, 64'(bitslip), 64'd0);
        chk({tag, "_locked"}, 64'(locked), 64'd0);
        chk({tag, "_fail"}, 64'(fail), 64'd0);
        chk({tag, "_slipcnt"}, 64'(slip_count), 64'd0);
        chk({tag, "_lane_err"}, 64'(lane_err), 64'd0);
        chk({tag, "_data_out"}, data_out, 64'd0);
        chk({tag, "_valid"}, 64'(data_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        align_start = 1'b0;
        off_init    = 3'd0;
        stuck_mask  = 8'h00;
        corrupt     = 1'b0;
        model_en    = 1'b1;
        model_clr   = 1'b1;
        use_free    = 1'b0;
        free_word   = '0;
        @(negedge divclk);
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n     = 1'b1;
        model_clr = 1'b0;
        tick();

        // 1: already aligned, no slips, lock at cycle 21
        train("t1", 0, 21, 1'b0, 60);

        // 2: three-bit offset
        model_reset(3'd3, 8'h00);
        train("t2", 3, 39, 1'b0, 100);

        // 3: lane 5 stuck, all positions exhausted
        model_reset(3'd7, 8'h20);
        train("t3", 7, 48, 1'b1, 150);
        chk("t3_lane_err", 64'(lane_err), 64'h20);
        repeat (3) tick();
        chk("t3_hold_fail", 64'(fail), 64'd1);
        chk("t3_hold_slipcnt", 64'(slip_count), 64'd7);
        chk("t3_hold_bitslip", 64'(bitslip), 64'd0);

        // 4: reset while a slip pulse is on the line
        model_reset(3'd3, 8'h00);
        align_start = 1'b1;
        tick();
        align_start = 1'b0;
        for (int i = 0; i < 20 && !bitslip; i++) tick();
        chk("t4_slip_seen", 64'(bitslip), 64'd1);
        rst_n = 1'b0;
        tick();
        chk_all_zero("t4_reset");
        rst_n = 1'b1;
        model_reset(3'd3, 8'h00);
        train("t4_rerun", 3, 39, 1'b0, 100);

        // 5: locked ignores arbitrary data, then retrain from a new offset
        use_free = 1'b1;
        for (int i = 0; i < 5; i++) begin
            free_word = {$urandom, $urandom};
            tick();
            chk("t5_free_data_out", data_out, exp_q);
            chk("t5_free_locked", 64'(locked), 64'd1);
            chk("t5_free_valid", 64'(data_valid), 64'd1);
        end
        use_free = 1'b0;
        off_init = 3'd5;
        tick();
        chk("t5_pre_locked", 64'(locked), 64'd1);
        train("t5", 2, 33, 1'b0, 80);

        // 6: mismatch on the last needed match, deserializer ignores the slip
        model_en    = 1'b0;
        align_start = 1'b1;
        tick();
        align_start = 1'b0;
        repeat (19) tick();
        chk("t6_c20_bitslip", 64'(bitslip), 64'd0);
        chk("t6_c20_locked", 64'(locked), 64'd0);
        corrupt = 1'b1;
        tick();
        corrupt = 1'b0;
        chk("t6_c21_bitslip", 64'(bitslip), 64'd1);
        chk("t6_c21_locked", 64'(locked), 64'd0);
        chk("t6_c21_lane_err", 64'(lane_err), 64'h01);
        repeat (20) tick();
        chk("t6_c41_locked", 64'(locked), 64'd0);
        tick();
        chk("t6_c42_locked", 64'(locked), 64'd1);
        chk("t6_c42_slipcnt", 64'(slip_count), 64'd1);
        chk("t6_c42_valid", 64'(data_valid), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
